if_fetch_unit: RTL and testbench

// - Decoupled IF stage: owns PC, issues in-order requests to an external instr memory/cache port, buffers

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_fetch_fifo.sv | 80 ++++++++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths, canonical NOP and the
// fetch buffer entry layout used between IF and ID.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Parity over a fetch word, available for a protected buffer variant.
  function automatic logic instr_parity(input logic [INSTR_WIDTH-1:0] instr);
    return ^instr;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage
// registers so a push becomes visible at the output on the following cycle.
module if_fetch_fifo_chk (
  input logic i_clk,
  input logic i_reset_n,
  input logic i_push,
  input logic i_pop,
  input logic i_flush,
  input logic i_full
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_push && i_full && !i_pop && !i_flush));

endmodule

module if_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign o_full    = (count_r == CW'(DEPTH));
  assign o_empty   = (count_r == CW'(0));
  assign o_count   = count_r;
  assign o_head    = mem_r[rd_ptr_r];
  assign do_pop_s  = i_pop && !o_empty && !i_flush;
  assign do_push_s = i_push && (!o_full || do_pop_s) && !i_flush && i_reset_n;

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge i_clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= i_push_data;
  end

  if_fetch_fifo_chk u_chk (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (i_push),
    .i_pop     (i_pop),
    .i_flush   (i_flush),
    .i_full    (o_full)
  );

endmodule

// File: rtl/if_fetch_unit.sv
// Decoupled instruction fetch: owns the PC, issues in-order memory requests,
// buffers returned words with their PC and hands them to ID over valid/ready.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int             XLEN        = riscv_pkg::XLEN,
  parameter int             INSTR_WIDTH = riscv_pkg::INSTR_WIDTH,
  parameter int             FETCH_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  localparam int            CW          = $clog2(FETCH_DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_redirect_valid,
  input  logic [XLEN-1:0]        i_redirect_pc,
  output logic                   o_imem_req_valid,
  input  logic                   i_imem_req_ready,
  output logic [XLEN-1:0]        o_imem_req_addr,
  input  logic                   i_imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
  output logic                   o_IF_valid,
  input  logic                   i_ID_ready,
  output logic [INSTR_WIDTH-1:0] o_IF_instr,
  output logic [XLEN-1:0]        o_IF_program_cntr,
  output logic [XLEN-1:0]        o_IF_program_cntr_next
);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_r;
  logic [CW-1:0]   drop_r;
  logic [CW-1:0]   inflight_s;
  logic [CW-1:0]   buf_count_s;
  logic [CW:0]     occupancy_s;
  logic [XLEN-1:0] tag_head_s;
  logic [XLEN-1:0] redirect_target_s;
  logic            tag_full_s;
  logic            tag_empty_s;
  logic            buf_full_s;
  logic            buf_empty_s;
  logic            accept_s;
  logic            rsp_ok_s;
  logic            buf_push_s;
  logic            buf_pop_s;
  entry_t          push_entry_s;
  entry_t          head_s;

  // Credits cover both outstanding requests and buffered words so the buffer can never overflow.
  assign occupancy_s       = {1'b0, inflight_s} + {1'b0, buf_count_s};
  assign o_imem_req_valid  = i_reset_n && !i_redirect_valid && !tag_full_s && !buf_full_s
                             && (occupancy_s < (CW+1)'(FETCH_DEPTH));
  assign o_imem_req_addr   = pc_r;
  assign accept_s          = o_imem_req_valid && i_imem_req_ready;
  assign rsp_ok_s          = i_imem_rsp_valid && !tag_empty_s;
  assign buf_push_s        = rsp_ok_s && (drop_r == CW'(0)) && !i_redirect_valid;
  assign buf_pop_s         = o_IF_valid && i_ID_ready;
  assign push_entry_s      = '{pc: tag_head_s, instr: i_imem_rsp_data};
  assign redirect_target_s = i_redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  assign o_IF_valid             = !buf_empty_s;
  assign o_IF_instr             = o_IF_valid ? head_s.instr : '0;
  assign o_IF_program_cntr      = o_IF_valid ? head_s.pc : '0;
  assign o_IF_program_cntr_next = o_IF_valid ? (head_s.pc + XLEN'(4)) : '0;

  if_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FETCH_DEPTH)) u_tag_q (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (accept_s),
    .i_push_data (pc_r),
    .i_pop       (rsp_ok_s),
    .i_flush     (1'b0),
    .o_head      (tag_head_s),
    .o_count     (inflight_s),
    .o_full      (tag_full_s),
    .o_empty     (tag_empty_s)
  );

  if_fetch_fifo #(.WIDTH(XLEN + INSTR_WIDTH), .DEPTH(FETCH_DEPTH)) u_rsp_q (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (buf_push_s),
    .i_push_data (push_entry_s),
    .i_pop       (buf_pop_s),
    .i_flush     (i_redirect_valid),
    .o_head      (head_s),
    .o_count     (buf_count_s),
    .o_full      (buf_full_s),
    .o_empty     (buf_empty_s)
  );

  // PC advance; a redirect overrides any sequential step.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pc_r <= RESET_PC;
    end else if (i_redirect_valid) begin
      pc_r <= redirect_target_s;
    end else if (accept_s) begin
      pc_r <= pc_r + XLEN'(4);
    end
  end

  // Stale-response counter: everything still in flight at a redirect is discarded on return.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      drop_r <= CW'(0);
    end else if (i_redirect_valid) begin
      drop_r <= inflight_s - CW'(rsp_ok_s);
    end else if (rsp_ok_s && (drop_r != CW'(0))) begin
      drop_r <= drop_r - CW'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: models the instruction memory and checks
// the delivered PC/instruction stream against epoch-based expectations.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic [31:0] if_instr, if_pc, if_next;

  always #5 clk = ~clk;

  if_fetch_unit #(.XLEN(32), .INSTR_WIDTH(32), .FETCH_DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .i_clk                  (clk),
    .i_reset_n              (rst_n),
    .i_redirect_valid       (redir_v),
    .i_redirect_pc          (redir_pc),
    .o_imem_req_valid       (req_valid),
    .i_imem_req_ready       (req_ready),
    .o_imem_req_addr        (req_addr),
    .i_imem_rsp_valid       (rsp_valid),
    .i_imem_rsp_data        (rsp_data),
    .o_IF_valid             (if_valid),
    .i_ID_ready             (id_ready),
    .o_IF_instr             (if_instr),
    .o_IF_program_cntr      (if_pc),
    .o_IF_program_cntr_next (if_next)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] nxt; int epoch; } rec_t;

  pend_t       pend_q[$];
  rec_t        got_q[$];
  rec_t        req_q[$];
  logic [31:0] epoch_start[$];
  int          epoch, cyc, last_due;
  int          p_req, p_id, lat_lo, lat_hi;
  int          total = 0, bad = 0;
  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_pc, s_instr, s_nxt;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive inputs at the falling edge, sample, log transfers that complete at the next rising edge.
  task automatic cycle(input logic rst_in, input logic do_redir, input logic [31:0] rpc);
    pend_t p;
    rec_t  r;
    int    lat;
    @(negedge clk);
    rst_n     = rst_in;
    redir_v   = do_redir;
    redir_pc  = rpc;
    req_ready = (int'($urandom_range(99)) < p_req);
    id_ready  = (int'($urandom_range(99)) < p_id);
    rsp_valid = 1'b0;
    rsp_data  = $urandom();
    if (!rst_in) begin
      pend_q.delete();
      last_due = cyc;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = instr_of(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    #1;
    s_req_valid = req_valid; s_req_addr = req_addr; s_if_valid = if_valid;
    s_pc = if_pc; s_instr = if_instr; s_nxt = if_next;
    if (!rst_in) begin
      epoch_start.push_back(RESET_PC);
      epoch++;
    end else begin
      if (req_valid && req_ready) begin
        lat    = int'($urandom_range(lat_hi, lat_lo));
        p.addr = req_addr;
        p.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = p.due;
        pend_q.push_back(p);
        r = '{pc: req_addr, instr: 32'h0, nxt: 32'h0, epoch: epoch};
        req_q.push_back(r);
      end
      if (if_valid && id_ready) begin
        r = '{pc: if_pc, instr: if_instr, nxt: if_next, epoch: epoch};
        got_q.push_back(r);
      end
      if (do_redir) begin
        epoch_start.push_back(rpc & 32'hFFFF_FFFC);
        epoch++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    got_q.delete(); req_q.delete(); epoch_start.delete();
    epoch_start.push_back(RESET_PC);
    epoch = 0;
  endtask

  task automatic test_reset();
    p_req = 100; p_id = 100; lat_lo = 1; lat_hi = 1;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    total++; if (s_if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid: got %b want 0", s_if_valid); end
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", s_req_valid); end
    total++; if ({s_pc, s_instr, s_nxt} !== 96'h0) begin bad++; $display("FAIL reset_data: got %h %h %h want 0", s_pc, s_instr, s_nxt); end
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_req_valid !== 1'b1) begin bad++; $display("FAIL reset_first_req: got %b want 1", s_req_valid); end
    total++; if (s_req_addr !== RESET_PC) begin bad++; $display("FAIL reset_first_addr: got %h want %h", s_req_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    p_req = 100; p_id = 100; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h0);
    total++; if (req_q.size() != 20) begin bad++; $display("FAIL stream_req_count: got %0d want 20", req_q.size()); end
    total++; if (got_q.size() != 18) begin bad++; $display("FAIL stream_no_gaps: got %0d want 18", got_q.size()); end
    foreach (req_q[i]) begin
      total++; if (req_q[i].pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_q[i].pc, 32'(4 * i)); end
    end
    foreach (got_q[i]) begin
      total++;
      if (got_q[i].pc !== 32'(4 * i) || got_q[i].instr !== instr_of(32'(4 * i)) || got_q[i].nxt !== 32'(4 * i + 4)) begin
        bad++; $display("FAIL stream_out[%0d]: got pc=%h instr=%h next=%h want pc=%h", i, got_q[i].pc, got_q[i].instr, got_q[i].nxt, 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    p_req = 100; p_id = 0; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      total++; if (pend_q.size() > 4) begin bad++; $display("FAIL bp_outstanding: got %0d want <=4", pend_q.size()); end
      if (i >= 2) begin
        total++;
        if (s_if_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== instr_of(32'h0)) begin
          bad++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h", i, s_if_valid, s_pc, s_instr, instr_of(32'h0));
        end
      end
    end
    total++; if (req_q.size() != 4) begin bad++; $display("FAIL bp_credit: got %0d requests want 4", req_q.size()); end
    p_id = 100;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h0);
    total++; if (got_q.size() < 10) begin bad++; $display("FAIL bp_resume: got %0d items want >=10", got_q.size()); end
    foreach (got_q[i]) begin
      total++;
      if (got_q[i].pc !== 32'(4 * i) || got_q[i].instr !== instr_of(32'(4 * i))) begin
        bad++; $display("FAIL bp_order[%0d]: got pc=%h instr=%h want pc=%h", i, got_q[i].pc, got_q[i].instr, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    p_req = 100; p_id = 100; lat_lo = 4; lat_hi = 4;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL redir_no_req: got %b want 0", s_req_valid); end
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_if_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_drop: got %b want 0", s_if_valid); end
    total++; if (s_req_addr !== 32'h0000_0100) begin bad++; $display("FAIL redir_req_addr: got %h want 00000100", s_req_addr); end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h0);
    total++;
    if (got_q.size() == 0) begin
      bad++; $display("FAIL redir_first_out: got no output want pc 00000100");
    end else if (got_q[0].pc !== 32'h100 || got_q[0].nxt !== 32'h104 || got_q[0].instr !== instr_of(32'h100)) begin
      bad++; $display("FAIL redir_first_out: got pc=%h next=%h instr=%h want 00000100/00000104", got_q[0].pc, got_q[0].nxt, got_q[0].instr);
    end
    foreach (got_q[i]) begin
      total++; if (got_q[i].pc !== 32'(32'h100 + 4 * i)) begin bad++; $display("FAIL redir_seq[%0d]: got %h want %h", i, got_q[i].pc, 32'(32'h100 + 4 * i)); end
    end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] expv[int];
    int          n3;
    p_req = 100; p_id = 100; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0203);
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_if_valid !== 1'b0) begin bad++; $display("FAIL coll_valid_drop: got %b want 0", s_if_valid); end
    total++; if (s_req_addr !== 32'h0000_0200) begin bad++; $display("FAIL coll_align: got %h want 00000200", s_req_addr); end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0300);
    cycle(1'b1, 1'b1, 32'h0000_0400);
    total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_req: got %b want 0", s_req_valid); end
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 32'h0);
    n3 = 0;
    foreach (got_q[i]) begin
      int e;
      e = got_q[i].epoch;
      if (!expv.exists(e)) expv[e] = epoch_start[e];
      if (e == 3) n3++;
      total++;
      if (e == 2 || got_q[i].pc !== expv[e] || got_q[i].instr !== instr_of(expv[e])) begin
        bad++; $display("FAIL coll_seq[%0d]: got epoch=%0d pc=%h want pc=%h (epoch 2 must be empty)", i, e, got_q[i].pc, expv[e]);
      end
      expv[e] = expv[e] + 32'd4;
    end
    total++; if (!expv.exists(1) || n3 == 0) begin bad++; $display("FAIL coll_progress: got epoch1=%0d epoch3_items=%0d want both present", expv.exists(1), n3); end
  endtask

  task automatic test_random();
    logic [31:0] expg[int];
    logic [31:0] expr[int];
    logic        rd;
    logic [31:0] tgt;
    p_req = 60; p_id = 60; lat_lo = 1; lat_hi = 3;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      rd  = (int'($urandom_range(99)) < 3);
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      cycle(1'b1, rd, tgt);
      total++; if (pend_q.size() > 4) begin bad++; $display("FAIL rand_outstanding: got %0d want <=4", pend_q.size()); end
    end
    total++; if (got_q.size() < 300) begin bad++; $display("FAIL rand_throughput: got %0d items want >=300", got_q.size()); end
    foreach (req_q[i]) begin
      int e;
      e = req_q[i].epoch;
      if (!expr.exists(e)) expr[e] = epoch_start[e];
      total++; if (req_q[i].pc !== expr[e]) begin bad++; $display("FAIL rand_req[%0d]: got %h want %h", i, req_q[i].pc, expr[e]); end
      expr[e] = expr[e] + 32'd4;
    end
    foreach (got_q[i]) begin
      int e;
      e = got_q[i].epoch;
      if (!expg.exists(e)) expg[e] = epoch_start[e];
      total++;
      if (got_q[i].pc !== expg[e] || got_q[i].instr !== instr_of(expg[e]) || got_q[i].nxt !== expg[e] + 32'd4) begin
        bad++; $display("FAIL rand_out[%0d]: got pc=%h instr=%h next=%h want pc=%h instr=%h", i, got_q[i].pc, got_q[i].instr, got_q[i].nxt, expg[e], instr_of(expg[e]));
      end
      expg[e] = expg[e] + 32'd4;
    end
  endtask

  task automatic test_reset_midstream_wrap();
    int wi;
    p_req = 100; p_id = 100; lat_lo = 1; lat_hi = 2;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_if_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", s_if_valid); end
    total++; if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin bad++; $display("FAIL mid_reset_req: got v=%b addr=%h want 1/%h", s_req_valid, s_req_addr, RESET_PC); end
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'hFFFF_FFF4);
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 32'h0);
    wi = -1;
    foreach (got_q[i]) if (got_q[i].pc === 32'hFFFF_FFFC && got_q[i].epoch == epoch) wi = i;
    total++;
    if (wi < 0 || wi + 1 >= got_q.size()) begin
      bad++; $display("FAIL wrap_seen: got no FFFFFFFC followed by another item want one");
    end else if (got_q[wi].nxt !== 32'h0 || got_q[wi+1].pc !== 32'h0 || got_q[wi+1].instr !== instr_of(32'h0)) begin
      bad++; $display("FAIL wrap: got next=%h then pc=%h instr=%h want 00000000", got_q[wi].nxt, got_q[wi+1].pc, got_q[wi+1].instr);
    end
    foreach (got_q[i]) begin
      if (got_q[i].epoch > 0 && got_q[i].epoch < epoch) begin
        total++; if (got_q[i].pc[31:8] !== 24'h0) begin bad++; $display("FAIL mid_reset_restart[%0d]: got %h want low addresses from RESET_PC", i, got_q[i].pc); end
      end
    end
  endtask

  initial begin
    epoch = 0; cyc = 0; last_due = 0;
    epoch_start.push_back(RESET_PC);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_random();
    test_reset_midstream_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
